hack_ram_sync_clr: RTL

- Parametrised synchronous single-port RAM for the HACK data/program memory path; next generation of the fixed 16-bit x 8K RAM.
- Adds configurable width and depth, selectable read-during-write mode, and an out-of-range address guard.
- Adds a hardware clear sequencer that fills memory after reset or on request, with busy/valid status for the CPU and memory-map logic.

---
 rtl/hack_ram_sync_clr.sv | 111 +++++++++++
 1 files changed

// File: rtl/hack_ram_sync_clr.sv
// ---------------------------------------------------------------------------
// hack_ram_sync_clr : parametrised single-port RAM with a hardware clear sequencer
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module hack_ram_sync_clr #(
  parameter int                 DATA_W         = 16,
  parameter int                 ADDR_W         = 13,
  parameter int                 DEPTH          = 8192,
  parameter int                 RDW_MODE       = 0,
  parameter int                 CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0]  CLEAR_VALUE    = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic              clear,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              busy
);

  localparam logic [0:0]        S_IDLE    = 1'b0;
  localparam logic [0:0]        S_CLEAR   = 1'b1;
  localparam logic [0:0]        RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              out_valid_q, out_valid_d;

  logic              in_range;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  assign in_range  = (32'(address) < 32'(DEPTH));
  assign mem_rdata = mem[address];

  // State register; the memory array itself is deliberately not reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_STATE;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (clear) state_d = S_CLEAR;
      S_CLEAR: if (cnt_q == LAST_ADDR) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A clear request wins over a same-cycle load: that edge writes nothing.
  always_comb begin
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = address;
    mem_wdata   = data;
    case (state_q)
      S_CLEAR: begin
        mem_we    = rst_n;
        mem_waddr = cnt_q;
        mem_wdata = CLEAR_VALUE;
        cnt_d     = (cnt_q == LAST_ADDR) ? '0 : cnt_q + 1'b1;
      end
      default: begin
        if (!clear) begin
          mem_we      = rst_n & load & in_range;
          out_valid_d = 1'b1;
          if (!in_range)
            out_d = '0;
          else if ((RDW_MODE != 0) && load)
            out_d = data;
          else
            out_d = mem_rdata;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = state_q;

endmodule

`default_nettype wire
